// File: rtl/ecc_drain_pkg.sv
// Shared defaults and types for the ECC FIFO read-side drain stage.
package ecc_drain_pkg;

  localparam int DW        = 10;
  localparam int BUF_DEPTH = 2;
  localparam int CNT_W     = 16;
  localparam int IDLE_THR  = 3;

  typedef logic [DW-1:0] data_t;

endpackage

// File: rtl/ecc_skid_buf.sv
// Two-entry circular skid buffer that soaks up the FIFO's one-cycle read
// latency. A simultaneous push and pop keeps the occupancy and advances
// both pointers; at full occupancy head equals tail, so the incoming word
// overwrites the slot that is being popped in the same cycle.
module ecc_skid_buf #(
  parameter int DW = ecc_drain_pkg::DW
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic [1:0]    count
);

  import ecc_drain_pkg::*;

  localparam logic [1:0] FULL = 2'(BUF_DEPTH);

  logic [DW-1:0] mem [2];
  logic          head;
  logic          tail;

  assign dout = mem[head];

  // Storage, pointers and occupancy; everything is discarded on reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      head   <= 1'b0;
      tail   <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[tail] <= din;
        tail      <= ~tail;
      end
      if (pop) begin
        head <= ~head;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // The read-credit rule upstream must never let a word arrive into a full buffer.
  a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
    !(push && !pop && (count == FULL)));

  // The consumer handshake only pops when a word is present.
  a_no_underflow: assert property (@(posedge clk) disable iff (!reset_n)
    !(pop && (count == 2'd0)));

endmodule

// File: rtl/ecc_fifo_drain.sv
// Read-side drain for the Hamming-ECC FIFO: issues read requests only when
// the skid buffer is guaranteed room for the returning word, delivers words
// on a valid/ready stream, and reports quiesce and a delivered-word count.
module ecc_fifo_drain #(
  parameter int DW        = ecc_drain_pkg::DW,
  parameter int BUF_DEPTH = ecc_drain_pkg::BUF_DEPTH,
  parameter int CNT_W     = ecc_drain_pkg::CNT_W,
  parameter int IDLE_THR  = ecc_drain_pkg::IDLE_THR
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_enable,
  input  logic             i_fifo_empty,
  output logic             o_fifo_rreq,
  input  logic [DW-1:0]    i_fifo_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [DW-1:0]    o_data,
  output logic             o_idle,
  output logic [CNT_W-1:0] o_word_cnt
);

  import ecc_drain_pkg::*;

  localparam logic [1:0] IDLE_MAX = 2'(IDLE_THR);

  logic [1:0] count;
  logic       inflight;
  logic       pop;
  logic [2:0] pending;
  logic [1:0] idle_cnt;
  logic       busy;

  assign o_valid = (count != 2'd0);
  assign pop     = o_valid & i_ready;

  // Words already owned by this stage after this cycle: buffered plus the
  // one in flight, minus the one leaving now. A pop frees a slot in the
  // same cycle, which is what lets streaming run at one word per clock.
  assign pending = 3'(count) + 3'(inflight) - 3'(pop);

  // Held low during reset so no read is launched while state is cleared.
  assign o_fifo_rreq = reset_n & i_enable & ~i_fifo_empty &
                       (pending < 3'(BUF_DEPTH));

  assign busy   = o_fifo_rreq | inflight | (count != 2'd0);
  assign o_idle = (idle_cnt == IDLE_MAX);

  ecc_skid_buf #(
    .DW(DW)
  ) u_skid (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (inflight),
    .pop     (pop),
    .din     (i_fifo_data),
    .dout    (o_data),
    .count   (count)
  );

  // A read issued this cycle returns data next cycle; remember it so the word is captured.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      inflight <= 1'b0;
    end else begin
      inflight <= o_fifo_rreq;
    end
  end

  // Count consecutive quiet cycles, saturating at the threshold.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idle_cnt <= 2'd0;
    end else if (busy) begin
      idle_cnt <= 2'd0;
    end else if (idle_cnt != IDLE_MAX) begin
      idle_cnt <= idle_cnt + 2'd1;
    end
  end

  // Running count of delivered words, wrapping silently.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      o_word_cnt <= '0;
    end else if (pop) begin
      o_word_cnt <= o_word_cnt + 1'b1;
    end
  end

endmodule
